// File: rtl/mux_nto1_pipe_pkg.sv
// Shared constants, skid-buffer state encoding and select-width helper for mux_nto1_pipe.
package mux_pkg;

    localparam int MUX_DEF_WIDTH = 32;
    localparam int MUX_MAX_N     = 64;

    typedef enum logic [1:0] {
        EMPTY = 2'b00,
        ONE   = 2'b01,
        TWO   = 2'b10
    } skid_state_e;

    function automatic int sel_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/mux_nto1_pipe_if.sv
// Request/response bundle for mux_nto1_pipe; err only exists when MUX_SEL_CHECK_EN is defined.
interface mux_nto1_pipe_if import mux_pkg::*; #(
    parameter int WIDTH = MUX_DEF_WIDTH,
    parameter int N     = 8
);
    localparam int SEL_W = sel_width(N);

    logic [N*WIDTH-1:0] i_bus;
    logic [SEL_W-1:0]   sel;
    logic               sel_valid;
    logic               in_ready;
    logic [WIDTH-1:0]   y;
    logic               y_valid;
    logic               y_ready;
`ifdef MUX_SEL_CHECK_EN
    logic               err;

    modport master (output i_bus, sel, sel_valid, y_ready,
                    input  in_ready, y, y_valid, err);
    modport slave  (input  i_bus, sel, sel_valid, y_ready,
                    output in_ready, y, y_valid, err);
`else
    modport master (output i_bus, sel, sel_valid, y_ready,
                    input  in_ready, y, y_valid);
    modport slave  (input  i_bus, sel, sel_valid, y_ready,
                    output in_ready, y, y_valid);
`endif

endinterface

// File: rtl/mux_skid_buf.sv
// Two-entry skid buffer: main register drives the output, skid absorbs one word of back-pressure.
module mux_skid_buf import mux_pkg::*; #(
    parameter int WIDTH = MUX_DEF_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push_valid,
    input  logic [WIDTH-1:0] push_data,
    output logic             push_ready,
    output logic             pop_valid,
    output logic [WIDTH-1:0] pop_data,
    input  logic             pop_ready
);

    skid_state_e      state;
    logic [WIDTH-1:0] main_q, skid_q;
    logic             push, pop;

    assign push = push_valid & push_ready;
    assign pop  = pop_valid & pop_ready;

    // Valid/ready are kept as their own flops so neither output is decoded from state.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= EMPTY;
            main_q     <= '0;
            skid_q     <= '0;
            pop_valid  <= 1'b0;
            push_ready <= 1'b1;
        end else begin
            case (state)
                EMPTY: if (push) begin
                    main_q    <= push_data;
                    state     <= ONE;
                    pop_valid <= 1'b1;
                end
                ONE: begin
                    if (push && pop) begin
                        main_q <= push_data;
                    end else if (push) begin
                        skid_q     <= push_data;
                        state      <= TWO;
                        push_ready <= 1'b0;
                    end else if (pop) begin
                        state     <= EMPTY;
                        pop_valid <= 1'b0;
                    end
                end
                TWO: if (pop) begin
                    main_q     <= skid_q;
                    state      <= ONE;
                    push_ready <= 1'b1;
                end
                default: begin
                    state      <= EMPTY;
                    pop_valid  <= 1'b0;
                    push_ready <= 1'b1;
                end
            endcase
        end
    end

    assign pop_data = main_q;

endmodule

// File: rtl/mux_nto1_pipe.sv
// N:1 word selector feeding a skid-buffered output; MUX_SEL_CHECK_EN adds a sticky out-of-range flag.
module mux_nto1_pipe import mux_pkg::*; #(
    parameter int WIDTH = MUX_DEF_WIDTH,
    parameter int N     = 8,
    parameter int SEL_W = sel_width(N)
) (
    input logic           clk,
    input logic           rst,
    mux_nto1_pipe_if.slave bus
);

    if (N < 2 || N > MUX_MAX_N) begin : g_bad_n
        $error("mux_nto1_pipe: N out of range");
    end

    logic [WIDTH-1:0] word;
    logic             push_ready;

    // An out-of-range select matches no input and falls through to the default word.
    always_comb begin
`ifdef MUX_SEL_CHECK_EN
        word = '0;
`else
        word = bus.i_bus[WIDTH-1:0];
`endif
        for (int k = 0; k < N; k++) begin
            if (bus.sel == SEL_W'(k)) word = bus.i_bus[k*WIDTH +: WIDTH];
        end
    end

`ifdef MUX_SEL_CHECK_EN
    logic sel_oob;
    logic err_q;

    assign sel_oob = (32'(bus.sel) >= N);

    always_ff @(posedge clk) begin
        if (rst)                                      err_q <= 1'b0;
        else if (bus.sel_valid && push_ready && sel_oob) err_q <= 1'b1;
    end

    assign bus.err = err_q;
`endif

    mux_skid_buf #(.WIDTH(WIDTH)) u_skid (
        .clk        (clk),
        .rst        (rst),
        .push_valid (bus.sel_valid),
        .push_data  (word),
        .push_ready (push_ready),
        .pop_valid  (bus.y_valid),
        .pop_data   (bus.y),
        .pop_ready  (bus.y_ready)
    );

    assign bus.in_ready = push_ready;

endmodule

// File: tb/tb_mux_nto1_pipe.sv
// Directed bench for mux_nto1_pipe: queue-based reference model checked every cycle plus literal checks.
module tb_mux_nto1_pipe;

    localparam int WIDTH = 32;
`ifdef MUX_SEL_CHECK_EN
    localparam int N = 6;
`else
    localparam int N = 8;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   tests = 0;
    int   fails = 0;

    always #5 clk = ~clk;

    mux_nto1_pipe_if #(.WIDTH(WIDTH), .N(N)) bus();

    mux_nto1_pipe #(.WIDTH(WIDTH), .N(N)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Reference model: a FIFO of at most two words, ready whenever fewer than two are held.
    logic [WIDTH-1:0] mq[$];
    logic             m_err = 1'b0;
    bit               started = 1'b0;

    function automatic logic [WIDTH-1:0] inp(input int k);
        return 32'h1000_0000 + 32'(k);
    endfunction

    always @(posedge clk) begin
        int s;
        logic [WIDTH-1:0] w;
        bit do_push, do_pop;
        started <= 1'b1;
        if (rst) begin
            mq.delete();
            m_err = 1'b0;
        end else begin
            do_push = bus.sel_valid && (mq.size() < 2);
            do_pop  = (mq.size() > 0) && bus.y_ready;
            s = int'(bus.sel);
            if (s < N) w = bus.i_bus[s*WIDTH +: WIDTH];
`ifdef MUX_SEL_CHECK_EN
            else begin
                w = '0;
                if (do_push) m_err = 1'b1;
            end
`else
            else w = bus.i_bus[WIDTH-1:0];
`endif
            if (do_pop) void'(mq.pop_front());
            if (do_push) mq.push_back(w);
        end
    end

    always @(negedge clk) begin
        if (started) begin
            tests++;
            if (bus.y_valid !== (mq.size() > 0) ||
                bus.in_ready !== (mq.size() < 2) ||
                (mq.size() > 0 && bus.y !== mq[0])
`ifdef MUX_SEL_CHECK_EN
                || bus.err !== m_err
`endif
               ) begin
                fails++;
                $display("FAIL model t=%0t: y=%h vld=%b rdy=%b, want y=%h vld=%b rdy=%b",
                         $time, bus.y, bus.y_valid, bus.in_ready,
                         (mq.size() > 0) ? mq[0] : 32'h0, mq.size() > 0, mq.size() < 2);
            end
        end
    end

    task automatic check(input string name, input logic [WIDTH-1:0] act, input logic [WIDTH-1:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h, want %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input int s);
        bus.sel       = 3'(s);
        bus.sel_valid = 1'b1;
        step();
        bus.sel_valid = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL timeout");
        $fatal(1, "timeout");
    end

    initial begin
        for (int k = 0; k < N; k++) bus.i_bus[k*WIDTH +: WIDTH] = inp(k);
        bus.sel       = '0;
        bus.sel_valid = 1'b0;
        bus.y_ready   = 1'b0;
        step();
        step();
        rst = 1'b0;
        check("reset_y", bus.y, 32'h0);
        check("reset_vld", 32'(bus.y_valid), 32'h0);
        check("reset_rdy", 32'(bus.in_ready), 32'h1);

        // single push, drained next cycle
        bus.y_ready = 1'b1;
        push(5);
        check("single_y", bus.y, 32'h1000_0005);
        check("single_vld", 32'(bus.y_valid), 32'h1);
        step();
        check("single_drain", 32'(bus.y_valid), 32'h0);

        // streaming sweep
        for (int s = 0; s < N; s++) begin
            bus.sel = 3'(s);
            bus.sel_valid = 1'b1;
            step();
            check("stream_y", bus.y, inp(s));
            check("stream_rdy", 32'(bus.in_ready), 32'h1);
        end
        bus.sel_valid = 1'b0;
        step();
        check("stream_end", 32'(bus.y_valid), 32'h0);

        // back-pressure fills skid
        bus.y_ready = 1'b0;
        push(2);
        push(3);
        check("bp_rdy", 32'(bus.in_ready), 32'h0);
        check("bp_y", bus.y, 32'h1000_0002);
        step();
        check("bp_hold", bus.y, 32'h1000_0002);
        bus.y_ready = 1'b1;
        step();
        check("bp_second", bus.y, 32'h1000_0003);
        check("bp_rdy_back", 32'(bus.in_ready), 32'h1);
        step();
        check("bp_drain", 32'(bus.y_valid), 32'h0);

        // push with pop while in ONE
        bus.y_ready = 1'b0;
        push(1);
        check("pp_first", bus.y, 32'h1000_0001);
        bus.y_ready = 1'b1;
        push(6 % N);
        check("pp_second", bus.y, inp(6 % N));
        check("pp_vld", 32'(bus.y_valid), 32'h1);
        step();
        check("pp_drain", 32'(bus.y_valid), 32'h0);

        // reset while full
        bus.y_ready = 1'b0;
        push(2);
        push(3);
        check("rst_full", 32'(bus.in_ready), 32'h0);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("mrst_y", bus.y, 32'h0);
        check("mrst_vld", 32'(bus.y_valid), 32'h0);
        check("mrst_rdy", 32'(bus.in_ready), 32'h1);
        bus.y_ready = 1'b1;
        push(4);
        check("mrst_push", bus.y, 32'h1000_0004);
        step();
        check("mrst_drain", 32'(bus.y_valid), 32'h0);

`ifdef MUX_SEL_CHECK_EN
        bus.y_ready = 1'b0;
        push(7);
        check("oob_y", bus.y, 32'h0);
        check("oob_vld", 32'(bus.y_valid), 32'h1);
        check("oob_err", 32'(bus.err), 32'h1);
        bus.y_ready = 1'b1;
        push(1);
        check("oob_next", bus.y, 32'h1000_0001);
        check("oob_sticky", 32'(bus.err), 32'h1);
        step();
        check("oob_sticky2", 32'(bus.err), 32'h1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("oob_clr", 32'(bus.err), 32'h0);
`endif

        step();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
